// File: rtl/lock_key_scheduler.sv
// lock_key_scheduler
// Loads two serial keys, holds the locked FSM in reset until both are present,
// then presents key0/key1 in phase windows, with a phase counter that runs in
// lockstep with the locked FSM's own counter.
module lock_key_scheduler #(
    parameter int KEY_W  = 6,
    parameter int WINDOW = 4,
    parameter int PH_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_sdi,
    input  logic             key_sval,
    input  logic             start,
    input  logic             stop,
    input  logic             zeroize,
    output logic [KEY_W-1:0] key_out,
    output logic             lock_rst,
    output logic             key_ready,
    output logic             running,
    output logic [PH_W-1:0]  phase,
    output logic             load_err
);

    localparam int SR_W   = 2 * KEY_W;
    localparam int CNT_W  = $clog2(SR_W + 1);
    localparam int PERIOD = 2 * WINDOW;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOADING,
        S_READY,
        S_RUN
    } state_t;

    state_t            state, state_nx;
    logic [SR_W-1:0]   sr, sr_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [PH_W-1:0]   phase_q, phase_nx;
    logic              err_q, err_nx;
    logic [SR_W-1:0]   sr_shifted;

    // New bits enter at the top and walk down, so the first bit ends in key0[0].
    assign sr_shifted = {key_sdi, sr[SR_W-1:1]};

    // State, key store, bit count, phase and sticky error registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_EMPTY;
            sr      <= '0;
            cnt     <= '0;
            phase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            cnt     <= cnt_nx;
            phase_q <= phase_nx;
            err_q   <= err_nx;
        end
    end

    // Next-state logic: zeroize > stop > start > key_sval, each only where it acts.
    // NOTE: every target gets a hold default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        phase_nx = phase_q;
        err_nx   = err_q;

        if (zeroize) begin
            state_nx = S_EMPTY;
            sr_nx    = '0;
            cnt_nx   = '0;
            phase_nx = '0;
            err_nx   = 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    // start/stop mean nothing without keys; only data moves us.
                    if (key_sval) begin
                        sr_nx    = sr_shifted;
                        cnt_nx   = CNT_W'(1);
                        state_nx = S_LOADING;
                    end
                end

                S_LOADING: begin
                    // Idle cycles simply hold, so gapped streams are fine.
                    if (key_sval) begin
                        sr_nx  = sr_shifted;
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(SR_W - 1)) begin
                            state_nx = S_READY;
                        end
                    end
                end

                S_READY: begin
                    if (stop) begin
                        phase_nx = '0;
                    end else if (start) begin
                        state_nx = S_RUN;
                        phase_nx = '0;
                    end else if (key_sval) begin
                        // Keys are sealed once complete; a reload needs zeroize.
                        err_nx = 1'b1;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        state_nx = S_READY;
                        phase_nx = '0;
                    end else begin
                        if (phase_q == PH_W'(PERIOD - 1)) begin
                            phase_nx = '0;
                        end else begin
                            phase_nx = phase_q + PH_W'(1);
                        end
                        if (key_sval) begin
                            err_nx = 1'b1;
                        end
                    end
                end

                default: begin
                    state_nx = S_EMPTY;
                end
            endcase
        end
    end

    assign running   = (state == S_RUN);
    assign lock_rst  = (state != S_RUN);
    assign key_ready = (state == S_READY) || (state == S_RUN);
    assign phase     = phase_q;
    assign load_err  = err_q;

    // Key select decoded purely from registers, so key_out settles right after
    // the rising edge and is stable for the locked FSM's falling-edge sample.
    always_comb begin
        key_out = '0;
        if (state == S_RUN) begin
            if (phase_q < PH_W'(WINDOW)) begin
                key_out = sr[KEY_W-1:0];
            end else begin
                key_out = sr[SR_W-1:KEY_W];
            end
        end
    end

endmodule

// File: doc/lock_key_scheduler.md
# lock_key_scheduler

Sequences the two-key schedule that drives the `keyinput` bus of a phase-locked behavioral FSM. The locked FSM checks key 1 during counter phases 0..WINDOW-1 and key 2 during phases WINDOW..2*WINDOW-1.

This block does three things:
- loads both keys serially from the key store;
- holds the locked FSM in reset until the keys are complete;
- presents the correct key on every phase, starting its own phase counter in lockstep with the locked FSM's counter.

## Interface
Parameters:
- `KEY_W`, default 6: width of each key and of `key_out`.
- `WINDOW`, default 4: cycles per key window. The full schedule period is 2*WINDOW.
- `PH_W`, default 3: phase counter width, equal to clog2(2*WINDOW).

Ports:
- `clk` in 1: the single clock. This block updates on the rising edge; the locked FSM samples on the falling edge.
- `rst` in 1: reset, asynchronous and active-high.
- `key_sdi` in 1: serial key data bit.
- `key_sval` in 1: `key_sdi` is valid this cycle.
- `start` in 1: begin running the schedule.
- `stop` in 1: end running the schedule.
- `zeroize` in 1: clear both keys and return to EMPTY.
- `key_out` out KEY_W: key presented to the locked FSM. `key_out[i]` drives `keyinput`i.
- `lock_rst` out 1: reset for the locked FSM and its phase counter.
- `key_ready` out 1: both keys are loaded.
- `running` out 1: the schedule is active (state RUN).
- `phase` out PH_W: current schedule phase.
- `load_err` out 1: sticky flag, set by an illegal load attempt.

## Operation
- Storage: shift register `sr` of width 2*KEY_W.
  - On an accepted bit: `sr` <= {`key_sdi`, `sr`[2*KEY_W-1:1]}.
  - After a full load: key0 = `sr`[KEY_W-1:0] and key1 = `sr`[2*KEY_W-1:KEY_W].
  - The first bit received lands in key0[0].
- FSM states: EMPTY, LOADING, READY, RUN. Priority order: `rst` > `zeroize` > `stop` > `start` > `key_sval`.
- EMPTY:
  - `lock_rst`=1, `key_out`=0.
  - `key_sval` shifts the bit in, sets bit count to 1, and moves to LOADING.
  - `start` is ignored.
- LOADING:
  - Each `key_sval` shifts a bit in and increments the count.
  - The shift that takes the count to 2*KEY_W moves to READY and sets `key_ready`=1.
  - Cycles without `key_sval` hold state, so gaps between bits are allowed.
  - `start` is ignored.
- READY:
  - `lock_rst`=1, `key_out`=0.
  - `start` (without `stop`) moves to RUN with `phase`=0 and `lock_rst`=0.
  - `key_sval` is ignored and sets `load_err`.
- RUN:
  - `phase` increments every cycle. Wrap: 2*WINDOW-1 -> 0.
  - `key_out` = key0 when `phase` < WINDOW, otherwise key1. It is decoded from registered `phase` and key registers only; there is no input-to-output combinational path.
  - `stop` moves to READY with `lock_rst`=1 and `phase`=0.
  - `key_sval` is ignored and sets `load_err`.
  - `start` has no effect.
- `zeroize` in any state, on the next edge:
  - `sr`=0 and bit count=0;
  - `key_ready`=0, `load_err`=0;
  - state EMPTY, `lock_rst`=1, `phase`=0.
- `load_err` clears only on `zeroize` or `rst`. To reload keys, assert `zeroize` first.

## Timing
- Reset values:
  - state EMPTY;
  - `sr`=0, bit count=0;
  - `key_out`=0, `lock_rst`=1;
  - `key_ready`=0, `running`=0, `phase`=0, `load_err`=0.
  - Reset mid-load discards partial keys.
- Load latency: `key_ready` rises on the rising edge that accepts the 2*KEY_W-th valid bit.
- Start latency: the rising edge that samples `start` in READY does all of the following at once:
  - enters RUN and sets `running`=1;
  - deasserts `lock_rst`;
  - drives `phase`=0 and `key_out`=key0.
- Phase alignment:
  - The next falling edge is the locked FSM's first clocked edge, and its counter is 0 there.
  - At the k-th falling edge after release, `phase` equals the locked counter value, (k-1) mod 2*WINDOW.
  - `key_out` is stable for a half cycle before every falling edge.
- Stop and zeroize in RUN: `lock_rst` rises on the same rising edge that leaves RUN. `key_out` is 0 from that edge.
- Simultaneous `start` and `stop` in READY: `stop` wins and the state stays READY.

## Test plan
- **Load and run.** Reset, then stream 1,0,1,1,0,1,1,0,0,0,0,1 on `key_sdi` with `key_sval`=1.
  - `key_ready`=1 after bit 12.
  - Pulse `start`: `lock_rst` falls.
  - `key_out`=6'b101101 for phases 0..3 and 6'b100001 for phases 4..7.
  - `phase` wraps 7->0 and key0 reappears.
- **Gapped load.** Same 12 bits with 1-3 idle cycles between them.
  - Same keys result.
  - `key_ready` stays 0 until bit 12.
  - `start` pulsed at bit 6 has no effect.
- **Stop and restart.** In RUN at `phase`=5, pulse `stop`.
  - READY, `lock_rst`=1, `phase`=0, `key_out`=0.
  - A later `start` resumes from `phase` 0 with key0.
- **Zeroize mid-run.** At `phase`=2, pulse `zeroize`.
  - Next edge: EMPTY, `key_ready`=0, `key_out`=0, `lock_rst`=1.
  - `start` is then ignored until 12 new bits are loaded.
- **Illegal load.** In RUN, assert `key_sval` with `key_sdi`=0.
  - `load_err`=1 sticky; keys and `phase` sequence are unchanged.
  - `zeroize` clears `load_err`.
- **Async reset.** Assert `rst` mid-load (after 7 bits) and mid-run, between clock edges.
  - All outputs take their reset values immediately.
  - A fresh 12-bit load is required to reach READY.
